// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road intersection controller: timed two-phase sequencing with all-red clearance,
// farm max-green limit and a flashing-yellow night mode; lamps decode the registered state.
module traffic_light_ctrl #(
    parameter int CNT_W   = 12,
    parameter int LONG_T  = 10,
    parameter int SHORT_T = 5,
    parameter int CLEAR_T = 2,
    parameter int BLINK_T = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             c,
    input  logic             flash,
    output logic             HG,
    output logic             HY,
    output logic             HR,
    output logic             FG,
    output logic             FY,
    output logic             FR,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] timer_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HGRN  = 3'd1;
    localparam logic [2:0] S_HYEL  = 3'd2;
    localparam logic [2:0] S_ARH   = 3'd3;
    localparam logic [2:0] S_FGRN  = 3'd4;
    localparam logic [2:0] S_FYEL  = 3'd5;
    localparam logic [2:0] S_ARF   = 3'd6;
    localparam logic [2:0] S_FLASH = 3'd7;

    localparam longint CNT_LIM = longint'(1) << CNT_W;

    generate
        if (LONG_T < 1 || SHORT_T < 1 || BLINK_T < 1 || CLEAR_T < 0 ||
            longint'(LONG_T - 1) >= CNT_LIM || longint'(SHORT_T - 1) >= CNT_LIM ||
            longint'(BLINK_T - 1) >= CNT_LIM || longint'(CLEAR_T - 1) >= CNT_LIM) begin : g_bad_param
            $error("traffic_light_ctrl: illegal duration parameters for CNT_W");
        end
    endgenerate

    // CLEAR_T may be 0; its reload value is then never used, so clamp it to keep it representable.
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_T - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(SHORT_T - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'((CLEAR_T > 0) ? CLEAR_T - 1 : 0);
    localparam logic [CNT_W-1:0] LD_BLINK = CNT_W'(BLINK_T - 1);
    localparam logic             HAS_CLR  = (CLEAR_T > 0);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_blink;

    logic             w_expired;
    logic [CNT_W-1:0] w_cnt_dec;

    assign w_expired = (r_cnt == '0);
    assign w_cnt_dec = w_expired ? r_cnt : (r_cnt - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (flash && (r_state != S_FLASH)) begin
            r_state <= S_FLASH;
            r_cnt   <= LD_BLINK;
            r_blink <= 1'b1;
        end else begin
            r_cnt <= w_cnt_dec;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state <= S_HGRN;
                        r_cnt   <= LD_LONG;
                    end
                end
                S_HGRN: begin
                    if (w_expired && c) begin
                        r_state <= S_HYEL;
                        r_cnt   <= LD_SHORT;
                    end
                end
                S_HYEL: begin
                    if (w_expired) begin
                        r_state <= HAS_CLR ? S_ARH : S_FGRN;
                        r_cnt   <= HAS_CLR ? LD_CLEAR : LD_LONG;
                    end
                end
                S_ARH: begin
                    if (w_expired) begin
                        r_state <= S_FGRN;
                        r_cnt   <= LD_LONG;
                    end
                end
                S_FGRN: begin
                    if (w_expired || !c) begin
                        r_state <= S_FYEL;
                        r_cnt   <= LD_SHORT;
                    end
                end
                S_FYEL: begin
                    if (w_expired) begin
                        r_state <= HAS_CLR ? S_ARF : S_HGRN;
                        r_cnt   <= HAS_CLR ? LD_CLEAR : LD_LONG;
                    end
                end
                S_ARF: begin
                    if (w_expired) begin
                        r_state <= S_HGRN;
                        r_cnt   <= LD_LONG;
                    end
                end
                S_FLASH: begin
                    if (!flash) begin
                        r_state <= HAS_CLR ? S_ARF : S_HGRN;
                        r_cnt   <= HAS_CLR ? LD_CLEAR : LD_LONG;
                        r_blink <= 1'b0;
                    end else if (w_expired) begin
                        r_cnt   <= LD_BLINK;
                        r_blink <= ~r_blink;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        HG = 1'b0;
        HY = 1'b0;
        HR = 1'b0;
        FG = 1'b0;
        FY = 1'b0;
        FR = 1'b0;
        case (r_state)
            S_HGRN:  begin HG = 1'b1; FR = 1'b1; end
            S_HYEL:  begin HY = 1'b1; FR = 1'b1; end
            S_FGRN:  begin HR = 1'b1; FG = 1'b1; end
            S_FYEL:  begin HR = 1'b1; FY = 1'b1; end
            S_FLASH: begin HY = r_blink; FY = r_blink; end
            default: begin HR = 1'b1; FR = 1'b1; end
        endcase
    end

    assign state_o = r_state;
    assign timer_o = r_cnt;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Drives two controllers (with and without all-red clearance) from shared random stimulus and
// compares state, timer and lamps every cycle against a phase/age reference model.
module tb_traffic_light_ctrl;

    localparam int LT = 10;
    localparam int ST = 5;
    localparam int BT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic c = 1'b0;
    logic flash = 1'b0;

    logic       hg0, hy0, hr0, fg0, fy0, fr0;
    logic       hg1, hy1, hr1, fg1, fy1, fr1;
    logic [2:0] st0, st1;
    logic [11:0] tm0, tm1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(.CNT_W(12), .LONG_T(LT), .SHORT_T(ST), .CLEAR_T(2), .BLINK_T(BT)) u_dut_clr (
        .clk(clk), .reset(reset), .start(start), .c(c), .flash(flash),
        .HG(hg0), .HY(hy0), .HR(hr0), .FG(fg0), .FY(fy0), .FR(fr0),
        .state_o(st0), .timer_o(tm0)
    );

    traffic_light_ctrl #(.CNT_W(12), .LONG_T(LT), .SHORT_T(ST), .CLEAR_T(0), .BLINK_T(BT)) u_dut_noclr (
        .clk(clk), .reset(reset), .start(start), .c(c), .flash(flash),
        .HG(hg1), .HY(hy1), .HR(hr1), .FG(fg1), .FY(fy1), .FR(fr1),
        .state_o(st1), .timer_o(tm1)
    );

    // Model: phase number plus cycles spent in it; timer and blink are derived from the age.
    int m_ph [2];
    int m_age[2];
    int m_clr[2] = '{2, 0};

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int dur(input int ph, input int clr);
        case (ph)
            1, 4:    return LT;
            2, 5:    return ST;
            3, 6:    return clr;
            7:       return BT;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_timer(input int ph, input int age, input int clr);
        int rem;
        if (ph == 0) return 0;
        if (ph == 7) return BT - 1 - (age % BT);
        rem = dur(ph, clr) - 1 - age;
        return (rem < 0) ? 0 : rem;
    endfunction

    function automatic int exp_lamps(input int ph, input int age);
        int b;
        b = ((age / BT) % 2 == 0) ? 1 : 0;
        case (ph)
            1:       return 6'b100001;
            2:       return 6'b010001;
            4:       return 6'b001100;
            5:       return 6'b001010;
            7:       return (b << 4) | (b << 1);
            default: return 6'b001001;
        endcase
    endfunction

    task automatic model_step(input int k);
        int ph, age, clr, nx;
        bit done;
        ph = m_ph[k]; age = m_age[k]; clr = m_clr[k];
        done = (age >= dur(ph, clr) - 1);
        nx = ph;
        if (reset) nx = -1;
        else if (flash && ph != 7) nx = 7;
        else begin
            case (ph)
                0: if (start) nx = 1;
                1: if (done && c) nx = 2;
                2: if (done) nx = (clr > 0) ? 3 : 4;
                3: if (done) nx = 4;
                4: if (done || !c) nx = 5;
                5: if (done) nx = (clr > 0) ? 6 : 1;
                6: if (done) nx = 1;
                7: if (!flash) nx = (clr > 0) ? 6 : 1;
                default: nx = 0;
            endcase
        end
        if (nx == -1) begin
            m_ph[k] = 0; m_age[k] = 0;
        end else if (nx != ph) begin
            m_ph[k] = nx; m_age[k] = 0;
        end else begin
            m_age[k] = age + 1;
        end
    endtask

    task automatic compare_all();
        check("state_clr", st0, m_ph[0]);
        check("timer_clr", tm0, exp_timer(m_ph[0], m_age[0], m_clr[0]));
        check("lamps_clr", {hg0, hy0, hr0, fg0, fy0, fr0}, exp_lamps(m_ph[0], m_age[0]));
        check("state_noclr", st1, m_ph[1]);
        check("timer_noclr", tm1, exp_timer(m_ph[1], m_age[1], m_clr[1]));
        check("lamps_noclr", {hg1, hy1, hr1, fg1, fy1, fr1}, exp_lamps(m_ph[1], m_age[1]));
        check("noclr_no_allred", ((st1 == 3'd3) || (st1 == 3'd6)) ? 1 : 0, 0);
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        m_ph  = '{0, 0};
        m_age = '{0, 0};

        repeat (3) cycle();
        reset = 1'b0;
        repeat (20) cycle();

        // Start with no farm car: highway green is held indefinitely.
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (49) cycle();

        // Car waiting: full cycle with max-green exit on the farm road.
        c = 1'b1;
        repeat (40) cycle();

        // Drop the car early in farm green.
        while (m_ph[0] != 4) cycle();
        cycle(); cycle();
        c = 1'b0;
        repeat (25) cycle();

        // Flash entered from highway yellow, then released.
        c = 1'b1;
        while (m_ph[0] != 2) cycle();
        flash = 1'b1;
        repeat (20) cycle();
        flash = 1'b0;
        repeat (15) cycle();

        // Reset in the middle of farm green.
        while (m_ph[0] != 4) cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (5) cycle();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) c = ~c;
            if ($urandom_range(0, 79) == 0) flash = ~flash;
            start = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 399) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised highway/farm-road intersection controller. It generalises the fixed long/short two-phase controller with several additions: configurable counter width and phase durations, an all-red clearance interval, a max-green limit on the farm road, and a flashing-yellow night mode. It is a single self-contained FSM plus one down-counter, and drives the six lamp outputs directly.

Parameters:
CNT_W, 12, width of the phase timer
LONG_T, 10, highway minimum green and farm maximum green, in cycles
SHORT_T, 5, yellow duration, in cycles
CLEAR_T, 2, all-red clearance duration, in cycles; 0 skips the all-red states
BLINK_T, 4, half-period of the flash-mode yellow blink, in cycles

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  leaves IDLE; ignored in all other states
c  input  1  farm-road car sensor, level
flash  input  1  night mode request, level
HG HY HR  output  1 each  highway green, yellow, red lamps
FG FY FR  output  1 each  farm-road green, yellow, red lamps
state_o  output  3  current state encoding
timer_o  output  CNT_W  current counter value

Behaviour:
- One clock domain. Reset is synchronous and active-high. Priority order: reset > flash > normal sequencing.
- Reset (sampled at a clk edge): after that edge, state=IDLE, cnt=0, blink=0, HR=FR=1, all other lamps 0.
- State encoding: IDLE=0, HGRN=1, HYEL=2, ARH=3, FGRN=4, FYEL=5, ARF=6, FLASH=7.
- Lamps are a combinational decode of the registered state and blink, so they change in the same cycle as state_o. Exactly one lamp per road is on, except in FLASH.
- Lamp decode per state:
  - IDLE, ARH, ARF: HR=FR=1
  - HGRN: HG=FR=1
  - HYEL: HY=FR=1
  - FGRN: HR=FG=1
  - FYEL: HR=FY=1
  - FLASH: HY=FY=blink, all others 0
- Timer rule: on entry to any timed state, cnt loads T-1. Each cycle in the state, cnt decrements if nonzero and holds at 0 otherwise. Define expired = (cnt==0). A state that exits on expiry therefore lasts exactly T cycles.
- Transitions:
  - IDLE -> HGRN when start=1; cnt loads LONG_T-1.
  - HGRN -> HYEL when expired && c=1. Otherwise HGRN is held with cnt at 0, so highway green lasts at least LONG_T cycles and is unbounded while c=0.
  - HYEL -> ARH on expiry (SHORT_T cycles). ARH -> FGRN on expiry (CLEAR_T cycles).
  - FGRN -> FYEL when c=0 or expired, whichever comes first. Farm green lasts between 1 and LONG_T cycles.
  - FYEL -> ARF on expiry (SHORT_T). ARF -> HGRN on expiry (CLEAR_T).
  - CLEAR_T=0: HYEL -> FGRN and FYEL -> HGRN directly; ARH and ARF are never entered.
- Flash mode:
  - flash=1 in any state other than FLASH: the next edge enters FLASH with blink=1 and cnt=BLINK_T-1. This includes IDLE, and takes precedence over start.
  - In FLASH: on expiry, blink toggles and cnt reloads BLINK_T-1.
  - flash=0 while in FLASH: next edge enters ARF with cnt=CLEAR_T-1, or HGRN with cnt=LONG_T-1 if CLEAR_T=0.
- Reset mid-operation, from any state including FLASH, returns to IDLE on the same edge. start must be reasserted to resume sequencing.
- Elaboration constraints: all durations >= 1 except CLEAR_T, which may be 0, and each duration minus 1 must fit in CNT_W bits. Violation is a compile-time error (generate-time check).
- timer_o equals cnt; it is 0 in IDLE.

Test Plan:
1. Reset held 3 cycles, then 20 cycles with no start -> state_o=0, HR=FR=1, all others 0 throughout.
2. start pulse with c=0 for 50 cycles -> HGRN from the next edge; timer_o counts 9..0 and then holds 0; HG stays on for all 50 cycles.
3. start with c=1 held -> HG 10 cycles, HY 5, HR+FR 2, FG 10 (max-green exit), FY 5, HR+FR 2, then HG. Check the exact cycle counts.
4. In FGRN, drop c at the 3rd FGRN cycle -> FYEL on the following edge; FG lasted 3 cycles; the rest of the sequence completes normally.
5. Assert flash during HYEL -> FLASH next cycle; HY=FY pattern 1 for 4 cycles, 0 for 4, repeating; deassert flash -> ARF for 2 cycles, then HGRN with timer_o=9.
6. Reset asserted mid-FGRN -> IDLE after that edge. Second build with CLEAR_T=0: HYEL goes directly to FGRN, and state_o never shows 3 or 6.
